// File: rtl/control_espirometro.sv
// Spirometer game controller: waits for a blow, integrates flow into a volume and
// compares it with a weight-derived target, allowing a fixed number of failed attempts.
module control_espirometro #(
    parameter logic [7:0]  UMBRAL_FLUJO = 8'd10,
    parameter logic [7:0]  FACTOR       = 8'd40,
    parameter logic [15:0] T_ESPERA     = 16'd5000,
    parameter logic [15:0] T_SOPLO      = 16'd3000,
    parameter logic [1:0]  INTENTOS     = 2'd3
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iCE,
    input  logic        iBoton,
    input  logic [7:0]  ivPeso,
    input  logic [7:0]  ivFlujo,
    output logic [2:0]  ovState,
    output logic [19:0] ovVolumen,
    output logic [2:0]  ovLED,
    output logic [1:0]  ovIntentos,
    output logic        oGana,
    output logic        oPierde
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ESPERA = 3'd1,
        SOPLO  = 3'd2,
        EVAL   = 3'd3,
        GANA   = 3'd4,
        PIERDE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] vol_q, vol_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  att_q, att_d;
    logic [7:0]  peso_q, peso_d;
    logic        prev_q, prev_d;

    logic        edge_w;
    logic        soplando;
    logic        fallo;
    logic [15:0] target;
    logic [15:0] timer_inc;
    logic [1:0]  att_inc;
    logic [20:0] suma;
    logic [19:0] vol_sat;

    assign edge_w    = iBoton & ~prev_q;
    assign soplando  = (ivFlujo >= UMBRAL_FLUJO);
    assign target    = {8'd0, peso_q} * {8'd0, FACTOR};
    assign timer_inc = timer_q + 16'd1;
    assign att_inc   = att_q + 2'd1;
    assign suma      = {1'b0, vol_q} + {13'd0, ivFlujo};
    assign vol_sat   = suma[20] ? 20'hFFFFF : suma[19:0];

    always_comb begin
        state_d = state_q;
        vol_d   = vol_q;
        timer_d = timer_q;
        att_d   = att_q;
        peso_d  = peso_q;
        prev_d  = prev_q;
        fallo   = 1'b0;
        if (iCE) begin
            prev_d = iBoton;
            case (state_q)
                IDLE: begin
                    if (edge_w && (ivPeso != 8'd0)) begin
                        peso_d  = ivPeso;
                        vol_d   = 20'd0;
                        timer_d = 16'd0;
                        att_d   = 2'd0;
                        state_d = ESPERA;
                    end
                end
                ESPERA: begin
                    if (soplando) begin
                        state_d = SOPLO;
                        timer_d = 16'd0;
                        vol_d   = {12'd0, ivFlujo};
                    end else if (timer_q == T_ESPERA - 16'd1) begin
                        fallo = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                SOPLO: begin
                    // A low sample ends the blow without being accumulated, even on the timeout tick.
                    if (!soplando) begin
                        state_d = EVAL;
                    end else begin
                        vol_d   = vol_sat;
                        timer_d = timer_inc;
                        if (timer_inc == T_SOPLO - 16'd1) begin
                            state_d = EVAL;
                        end
                    end
                end
                EVAL: begin
                    if (vol_q >= {4'd0, target}) begin
                        state_d = GANA;
                    end else begin
                        fallo = 1'b1;
                    end
                end
                GANA, PIERDE: begin
                    if (edge_w) begin
                        state_d = IDLE;
                        vol_d   = 20'd0;
                        timer_d = 16'd0;
                        att_d   = 2'd0;
                        peso_d  = 8'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (fallo) begin
                att_d = att_inc;
                if (att_inc == INTENTOS) begin
                    state_d = PIERDE;
                end else begin
                    state_d = ESPERA;
                    timer_d = 16'd0;
                    vol_d   = 20'd0;
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            vol_q   <= 20'd0;
            timer_q <= 16'd0;
            att_q   <= 2'd0;
            peso_q  <= 8'd0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vol_q   <= vol_d;
            timer_q <= timer_d;
            att_q   <= att_d;
            peso_q  <= peso_d;
            prev_q  <= prev_d;
        end
    end

    logic [21:0] v1, v2, v4, t1, t3;
    logic [2:0]  led_w;

    assign v1 = {2'b00, vol_q};
    assign v2 = {1'b0, vol_q, 1'b0};
    assign v4 = {vol_q, 2'b00};
    assign t1 = {6'd0, target};
    assign t3 = t1 + {5'd0, target, 1'b0};

    // With no patient latched the target is zero; report no progress rather than full.
    always_comb begin
        led_w = 3'd0;
        if (target == 16'd0)  led_w = 3'd0;
        else if (v1 >= t1)    led_w = 3'd4;
        else if (v4 >= t3)    led_w = 3'd3;
        else if (v2 >= t1)    led_w = 3'd2;
        else if (v4 >= t1)    led_w = 3'd1;
        else                  led_w = 3'd0;
    end

    assign ovState    = state_q;
    assign ovVolumen  = vol_q;
    assign ovLED      = led_w;
    assign ovIntentos = att_q;
    assign oGana      = (state_q == GANA);
    assign oPierde    = (state_q == PIERDE);

endmodule

// File: tb/tb_control_espirometro.sv
// Bench for control_espirometro: four instances with different FACTOR/T_SOPLO share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_control_espirometro;

    localparam int N = 4;
    localparam logic [N-1:0][7:0]  FACTS = {8'd40, 8'd1, 8'd255, 8'd40};
    localparam logic [N-1:0][15:0] TSOPS = {16'd5000, 16'd30, 16'd30, 16'd30};
    localparam int TESP   = 10;
    localparam int UMBRAL = 10;
    localparam int NINT   = 3;
    localparam int VMAX   = 1048575;

    logic       clk = 1'b0;
    logic       rst, ce, boton;
    logic [7:0] peso, flujo;

    logic [2:0]  st[N];
    logic [19:0] vol[N];
    logic [2:0]  led[N];
    logic [1:0]  att[N];
    logic        gana[N];
    logic        pierde[N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        control_espirometro #(
            .UMBRAL_FLUJO(8'd10),
            .FACTOR      (FACTS[g]),
            .T_ESPERA    (16'd10),
            .T_SOPLO     (TSOPS[g]),
            .INTENTOS    (2'd3)
        ) u_dut (
            .iClk      (clk),
            .iReset    (rst),
            .iCE       (ce),
            .iBoton    (boton),
            .ivPeso    (peso),
            .ivFlujo   (flujo),
            .ovState   (st[g]),
            .ovVolumen (vol[g]),
            .ovLED     (led[g]),
            .ovIntentos(att[g]),
            .oGana     (gana[g]),
            .oPierde   (pierde[g])
        );
    end

    int checks = 0;
    int errors = 0;

    int m_st[N], m_vol[N], m_tim[N], m_att[N], m_peso[N];
    bit m_prev[N];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int led_ref(input int v, input int t);
        if (t == 0)           return 0;
        if (v >= t)           return 4;
        if (4 * v >= 3 * t)   return 3;
        if (2 * v >= t)       return 2;
        if (4 * v >= t)       return 1;
        return 0;
    endfunction

    // Reference behaviour: one sample tick of the game for each instance.
    task automatic model_step(input bit r, input bit c, input bit b, input int p, input int f);
        for (int k = 0; k < N; k++) begin
            bit pressed;
            bit failed;
            int tgt;
            if (r) begin
                m_st[k] = 0; m_vol[k] = 0; m_tim[k] = 0;
                m_att[k] = 0; m_peso[k] = 0; m_prev[k] = 0;
            end else if (c) begin
                pressed = b && !m_prev[k];
                m_prev[k] = b;
                tgt = m_peso[k] * int'(FACTS[k]);
                failed = 0;
                case (m_st[k])
                    0: if (pressed && p != 0) begin
                        m_peso[k] = p; m_vol[k] = 0; m_tim[k] = 0; m_att[k] = 0; m_st[k] = 1;
                    end
                    1: if (f >= UMBRAL) begin
                        m_st[k] = 2; m_tim[k] = 0; m_vol[k] = f;
                    end else if (m_tim[k] == TESP - 1) failed = 1;
                    else m_tim[k]++;
                    2: if (f < UMBRAL) m_st[k] = 3;
                    else begin
                        m_vol[k] = (m_vol[k] + f > VMAX) ? VMAX : m_vol[k] + f;
                        m_tim[k]++;
                        if (m_tim[k] == int'(TSOPS[k]) - 1) m_st[k] = 3;
                    end
                    3: if (m_vol[k] >= tgt) m_st[k] = 4;
                    else failed = 1;
                    default: if (pressed) begin
                        m_st[k] = 0; m_vol[k] = 0; m_att[k] = 0; m_peso[k] = 0; m_tim[k] = 0;
                    end
                endcase
                if (failed) begin
                    m_att[k]++;
                    if (m_att[k] == NINT) m_st[k] = 5;
                    else begin
                        m_st[k] = 1; m_tim[k] = 0; m_vol[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("state%0d", k),  int'(st[k]),   m_st[k]);
            chk($sformatf("vol%0d", k),    int'(vol[k]),  m_vol[k]);
            chk($sformatf("led%0d", k),    int'(led[k]),  led_ref(m_vol[k], m_peso[k] * int'(FACTS[k])));
            chk($sformatf("att%0d", k),    int'(att[k]),  m_att[k]);
            chk($sformatf("gana%0d", k),   int'(gana[k]), int'(m_st[k] == 4));
            chk($sformatf("pierde%0d", k), int'(pierde[k]), int'(m_st[k] == 5));
        end
    endtask

    task automatic cycle(input bit r, input bit c, input bit b, input logic [7:0] p, input logic [7:0] f);
        rst = r; ce = c; boton = b; peso = p; flujo = f;
        @(posedge clk);
        model_step(r, c, b, int'(p), int'(f));
        #1;
        check_all();
    endtask

    task automatic tick(input bit b, input logic [7:0] p, input logic [7:0] f);
        cycle(1'b0, 1'b1, b, p, f);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
        cycle(1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic press(input logic [7:0] p);
        tick(1'b0, p, 8'd0);
        tick(1'b1, p, 8'd0);
    endtask

    initial begin
        bit b_r;
        logic [7:0] f_r, p_r;
        rst = 1'b1; ce = 1'b0; boton = 1'b0; peso = 8'd0; flujo = 8'd0;

        do_reset();
        for (int k = 0; k < N; k++) begin
            chk("rst_state", int'(st[k]), 0);
            chk("rst_vol",   int'(vol[k]), 0);
            chk("rst_led",   int'(led[k]), 0);
        end

        // Winning blow: 20 samples of 100 against target 2000.
        do_reset();
        press(8'd50);
        for (int i = 0; i < 20; i++) tick(1'b0, 8'd50, 8'd100);
        tick(1'b0, 8'd50, 8'd0);
        chk("win_eval_state", int'(st[0]), 3);
        chk("win_eval_vol",   int'(vol[0]), 2000);
        tick(1'b0, 8'd50, 8'd0);
        chk("win_state", int'(st[0]), 4);
        chk("win_gana",  int'(gana[0]), 1);
        chk("win_led",   int'(led[0]), 4);
        tick(1'b0, 8'd50, 8'd0);
        chk("win_hold_vol", int'(vol[0]), 2000);
        press(8'd50);
        chk("win_back_idle", int'(st[0]), 0);
        chk("win_clear_vol", int'(vol[0]), 0);

        // Three short blows lose the game.
        do_reset();
        press(8'd50);
        for (int a = 0; a < 3; a++) begin
            for (int i = 0; i < 5; i++) tick(1'b0, 8'd50, 8'd100);
            tick(1'b0, 8'd50, 8'd0);
            chk("short_eval_led", int'(led[0]), 1);
            chk("short_eval_st",  int'(st[0]), 3);
            tick(1'b0, 8'd50, 8'd0);
            chk("short_att", int'(att[0]), a + 1);
            chk("short_st",  int'(st[0]), (a == 2) ? 5 : 1);
        end
        chk("short_pierde", int'(pierde[0]), 1);

        // Never blowing: wait timeouts consume attempts.
        do_reset();
        press(8'd50);
        for (int i = 0; i < 10; i++) tick(1'b0, 8'd50, 8'd0);
        chk("wait_att1", int'(att[0]), 1);
        chk("wait_st1",  int'(st[0]), 1);
        for (int i = 0; i < 20; i++) tick(1'b0, 8'd50, 8'd0);
        chk("wait_lose", int'(st[0]), 5);
        chk("wait_att3", int'(att[0]), 3);

        // Blow timeout at maximum flow, two factors.
        do_reset();
        press(8'd255);
        for (int i = 0; i < 30; i++) tick(1'b0, 8'd255, 8'd255);
        chk("tmo_st_f255",  int'(st[1]), 3);
        chk("tmo_vol_f255", int'(vol[1]), 7650);
        chk("tmo_st_f1",    int'(st[2]), 3);
        tick(1'b0, 8'd255, 8'd255);
        chk("tmo_fail_st",  int'(st[1]), 1);
        chk("tmo_fail_att", int'(att[1]), 1);
        chk("tmo_win_f1",   int'(gana[2]), 1);

        // Reset mid-blow with iCE low, then a press with zero weight.
        do_reset();
        press(8'd50);
        tick(1'b0, 8'd50, 8'd100);
        tick(1'b0, 8'd50, 8'd100);
        chk("mid_soplo", int'(st[0]), 2);
        cycle(1'b1, 1'b0, 1'b1, 8'd50, 8'd100);
        chk("mid_rst_st",  int'(st[0]), 0);
        chk("mid_rst_vol", int'(vol[0]), 0);
        chk("mid_rst_led", int'(led[0]), 0);
        tick(1'b1, 8'd0, 8'd0);
        chk("zero_peso_idle", int'(st[0]), 0);

        // Long blow on the long-timeout instance saturates the volume.
        do_reset();
        press(8'd255);
        for (int i = 0; i < 4200; i++) tick(1'b0, 8'd255, 8'd255);
        chk("sat_vol", int'(vol[3]), VMAX);
        chk("sat_st",  int'(st[3]), 2);
        tick(1'b0, 8'd255, 8'd0);
        tick(1'b0, 8'd255, 8'd0);
        chk("sat_win", int'(gana[3]), 1);

        // Randomised play with gated ticks and occasional resets.
        b_r = 1'b0; f_r = 8'd0; p_r = 8'd20;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) b_r = ~b_r;
            if ($urandom_range(0, 5) == 0)
                f_r = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(10, 255));
            if ($urandom_range(0, 7) == 0)
                p_r = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 80));
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), b_r, p_r, f_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_espirometro.md
CONTROL_ESPIROMETRO -- requirements
Module: control_espirometro

Interface
REQ-001 Parameter UMBRAL_FLUJO, default 8'd10: minimum flow sample counted as blowing.
REQ-002 Parameter FACTOR, default 8'd40: volume units required per weight unit.
REQ-003 Parameter T_ESPERA, default 16'd5000: ticks allowed to start blowing.
REQ-004 Parameter T_SOPLO, default 16'd3000: maximum ticks of one blow.
REQ-005 Parameter INTENTOS, default 2'd3: failed attempts allowed before loss.
REQ-006 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-007 iClk  in  1  system clock; all state on rising edge.
REQ-008 iReset  in  1  synchronous, active-high reset.
REQ-009 iCE  in  1  sample tick; all non-reset state advances only when iCE=1.
REQ-010 iBoton  in  1  user button, level; only rising edges are used.
REQ-011 ivPeso  in  8  patient weight, latched at start.
REQ-012 ivFlujo  in  8  flow sample, valid on iCE cycles.
REQ-013 ovState  out  3  state: 0 IDLE, 1 ESPERA, 2 SOPLO, 3 EVAL, 4 GANA, 5 PIERDE.
REQ-014 ovVolumen  out  20  accumulated volume of current blow.
REQ-015 ovLED  out  3  progress level 0..4.
REQ-016 ovIntentos  out  2  failed attempts so far.
REQ-017 oGana / oPierde  out  1 each  high while in GANA / PIERDE.

Function
REQ-018 Button edge SHALL be detected against a previous-value register updated only on iCE cycles; edge = iBoton & ~prev.
REQ-019 Target SHALL be the 16-bit product of latched weight and FACTOR.
REQ-020 IDLE: button edge with ivPeso!=0 SHALL latch ivPeso, clear volume, timer and attempts, and go to ESPERA; edge with ivPeso=0 SHALL stay in IDLE.
REQ-021 ESPERA: the timer increments every tick.
- ivFlujo>=UMBRAL_FLUJO: go to SOPLO, clear timer, load volume with that sample.
- Otherwise, timer reaching T_ESPERA-1: counts as a failed attempt (REQ-024).
REQ-022 SOPLO: each tick with ivFlujo>=UMBRAL_FLUJO SHALL add the sample to volume, saturating at 20'hFFFFF, and increment the timer.
- ivFlujo<UMBRAL_FLUJO: go to EVAL with no accumulation.
- Timer reaching T_SOPLO-1: go to EVAL after accumulating that sample.
- Both on the same tick: single transition to EVAL; the low sample is not added.
REQ-023 EVAL SHALL last one tick: volume>=target goes to GANA; otherwise the tick counts as a failed attempt.
REQ-024 Failed attempt: attempts+1; if the new count equals INTENTOS, go to PIERDE; else go to ESPERA with timer and volume cleared.
REQ-025 GANA/PIERDE SHALL hold all outputs; a button edge SHALL return to IDLE and clear volume, attempts and latched weight.
REQ-026 Button edges in ESPERA, SOPLO and EVAL SHALL be ignored.
REQ-027 ovLED: 4 if volume>=target; 3 if 4*volume>=3*target; 2 if 2*volume>=target; 1 if 4*volume>=target; else 0.
- Products computed at 22 bits, no overflow.
- Combinational from registered volume and target.
REQ-028 Timer and attempts SHALL never wrap; any illegal state code SHALL go to IDLE on the next tick.
REQ-029 With iCE=0, all registers SHALL hold, including the edge-detect register.

Reset
REQ-030 iReset=1 SHALL win over iCE and SHALL force the following on the next edge:
- state IDLE; volume, timer, attempts, latched weight 0; edge register 0.
- Hence ovState=0, ovVolumen=0, ovLED=0, ovIntentos=0, oGana=0, oPierde=0.
REQ-031 Reset asserted mid-blow SHALL discard all progress, with no partial update on that edge.

Verification (T_ESPERA=10, T_SOPLO=30, iCE every cycle)
REQ-032 Peso=50 (target 2000), button, flow 100 for 20 ticks then 0 -> ovVolumen=2000, EVAL one tick, GANA, ovLED=4.
REQ-033 Peso=50, three blows of flow 100 for 5 ticks -> ovIntentos 1,2, then PIERDE; ovLED=1 after each blow.
REQ-034 Peso=50, button, flow 0 held -> after 10 ticks ovIntentos=1, state back to ESPERA; after 30 ticks PIERDE.
REQ-035 Peso=255, FACTOR=255, flow 255 held 30 ticks -> timeout exit, ovVolumen=7650, no saturation error; flow 255 with FACTOR=1 -> GANA.
REQ-036 Reset asserted mid-SOPLO with iCE=0 -> all outputs 0 next edge; button with ivPeso=0 -> stays IDLE.
